// File: rtl/nonlinear_seq.sv
// nonlinear_seq: WIDTH-bit substitution unit, one 32-bit slice per cycle.
// Modes: ANF nibble S-box from a mask bank, AES S, AES inverse S, bypass.
module nonlinear_seq #(
  parameter int WIDTH = 128,
  parameter int NMASK = 4,
  localparam int NSLICE = WIDTH / 32,
  localparam int SW = (NMASK > 1) ? $clog2(NMASK) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mask_we,
  input  logic [SW-1:0]    mask_waddr,
  input  logic [63:0]      mask_wdata,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_mode,
  input  logic [SW-1:0]    in_msel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy
);

  localparam int CW = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

  state_t           state, nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] op_q;
  logic [WIDTH-1:0] res_q;
  logic [1:0]       mode_q;
  logic [63:0]      mask_q;
  logic [63:0]      bank [NMASK];
  logic             accept;
  logic             last;
  logic [31:0]      sl_in;
  logic [31:0]      sl_out;

  function automatic logic [3:0] anf4(
    input logic [63:0] m,
    input logic [3:0]  a
  );
    logic [3:0] y;
    logic       p;
    y = '0;
    for (int j = 0; j < 4; j++) begin
      for (int i = 0; i < 16; i++) begin
        p = 1'b1;
        for (int k = 0; k < 4; k++)
          if (i[k]) p = p & a[k];
        y[3-j] = y[3-j] ^ (m[63-16*j-i] & p);
      end
    end
    return y;
  endfunction

  function automatic logic [7:0] gmul(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [7:0] r;
    logic [7:0] t;
    r = '0;
    t = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r = r ^ t;
      t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1b : 8'h00);
    end
    return r;
  endfunction

  // a^254 is the field inverse, and maps 0 to 0
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] t;
    r = 8'h01;
    t = a;
    for (int k = 1; k < 8; k++) begin
      t = gmul(t, t);
      r = gmul(r, t);
    end
    return r;
  endfunction

  function automatic logic [7:0] aes_byte(
    input logic [7:0] b,
    input logic       dec
  );
    logic [7:0] x;
    logic [7:0] v;
    x = dec ? ({b[6:0], b[7]} ^ {b[4:0], b[7:5]}
             ^ {b[1:0], b[7:2]} ^ 8'h05) : b;
    v = ginv(x);
    if (!dec)
      v = v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]}
        ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
    return v;
  endfunction

  assign last  = (cnt == CW'(NSLICE - 1));
  assign sl_in = op_q[32*int'(cnt) +: 32];

  always_comb begin
    sl_out = sl_in;
    unique case (1'b1)
      (mode_q == 2'b00):
        for (int n = 0; n < 8; n++)
          sl_out[4*n +: 4] = anf4(mask_q, sl_in[4*n +: 4]);
      (mode_q == 2'b01),
      (mode_q == 2'b10):
        for (int n = 0; n < 4; n++)
          sl_out[8*n +: 8] = aes_byte(sl_in[8*n +: 8], mode_q[1]);
      default: sl_out = sl_in;
    endcase
  end

  always_comb begin
    nxt       = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    unique case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) nxt = S_BUSY;
      end
      S_BUSY: begin
        busy = 1'b1;
        if (last) nxt = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) nxt = in_valid ? S_BUSY : S_IDLE;
      end
      default: nxt = S_IDLE;
    endcase
  end

  assign accept   = in_valid & in_ready;
  assign out_data = res_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      op_q   <= '0;
      res_q  <= '0;
      mode_q <= 2'b00;
      mask_q <= '0;
    end else begin
      if (accept) begin
        cnt    <= '0;
        op_q   <= in_data;
        mode_q <= in_mode;
        mask_q <= (int'(in_msel) < NMASK) ? bank[in_msel] : 64'h0;
      end else if (state == S_BUSY) begin
        cnt <= last ? '0 : cnt + 1'b1;
      end
      if (state == S_BUSY)
        res_q[32*int'(cnt) +: 32] <= sl_out;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < NMASK; s++) bank[s] <= '0;
    end else if (mask_we && int'(mask_waddr) < NMASK) begin
      bank[mask_waddr] <= mask_wdata;
    end
  end

endmodule

// File: tb/tb_nonlinear_seq.sv
// tb_nonlinear_seq: scoreboard bench for nonlinear_seq at WIDTH=128.
// Expected results are queued on accept and compared on out_valid.
module tb_nonlinear_seq;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         mask_we;
  logic [1:0]   mask_waddr;
  logic [63:0]  mask_wdata;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic [1:0]   in_mode;
  logic [1:0]   in_msel;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic         busy;

  int checks = 0;
  int failures = 0;

  logic [127:0] sb [$];
  logic [7:0]   sbox [256];
  logic [7:0]   isbox [256];

  localparam logic [63:0] M_ID  = 64'h0080080020004000;
  localparam logic [63:0] M_INV = 64'h80808800A000C000;

  always #5 clk = ~clk;

  nonlinear_seq #(.WIDTH(128), .NMASK(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .mask_we(mask_we), .mask_waddr(mask_waddr),
    .mask_wdata(mask_wdata),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_mode(in_mode),
    .in_msel(in_msel),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .busy(busy)
  );

  task automatic build_sbox;
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1B : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b00};
      q = q ^ {q[3:0], 4'h0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]}
        ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
      sbox[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sbox[0] = 8'h63;
    for (int i = 0; i < 256; i++) isbox[sbox[i]] = 8'(i);
  endtask

  function automatic logic [127:0] aes_model(
    input logic [127:0] d, input logic dec);
    logic [127:0] r;
    for (int n = 0; n < 16; n++)
      r[8*n +: 8] = dec ? isbox[d[8*n +: 8]] : sbox[d[8*n +: 8]];
    return r;
  endfunction

  function automatic logic [127:0] anf_model(
    input logic [63:0] m, input logic [127:0] d);
    logic [127:0] r;
    logic [3:0] a, y;
    logic p;
    for (int n = 0; n < 32; n++) begin
      a = d[4*n +: 4];
      y = 4'h0;
      for (int j = 0; j < 4; j++)
        for (int i = 0; i < 16; i++) begin
          p = 1'b1;
          for (int k = 0; k < 4; k++)
            if (((i >> k) & 1) == 1) p = p & a[k];
          y[3-j] = y[3-j] ^ (m[63-16*j-i] & p);
        end
      r[4*n +: 4] = y;
    end
    return r;
  endfunction

  task automatic load_mask(input logic [1:0] s, input logic [63:0] v);
    mask_we = 1'b1;
    mask_waddr = s;
    mask_wdata = v;
    @(posedge clk); #1;
    mask_we = 1'b0;
  endtask

  task automatic send(input logic [127:0] d, input logic [1:0] md,
                      input logic [1:0] ms, input logic [127:0] exp);
    int n;
    in_valid = 1'b1;
    in_data = d;
    in_mode = md;
    in_msel = ms;
    n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (!in_ready) begin
      failures++;
      $display("FAIL send_timeout got in_ready=%b need 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    sb.push_back(exp);
  endtask

  task automatic drain(output int n, output int b);
    n = 0;
    b = 0;
    while (!out_valid && n < 50) begin
      if (busy) b++;
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic ack;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  function automatic logic [127:0] pop;
    if (sb.size() == 0) return 'x;
    return sb.pop_front();
  endfunction

  task automatic test_reset;
    rst_n = 1'b0;
    #12;
    checks++;
    if ({in_ready, out_valid, busy} !== 3'b100) begin
      failures++;
      $display("FAIL reset_flags got %b need 100",
               {in_ready, out_valid, busy});
    end
    checks++;
    if (out_data !== '0) begin
      failures++;
      $display("FAIL reset_data got %h need 0", out_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_anf_identity;
    logic [127:0] d, e;
    int n, b;
    d = 128'h0123456789ABCDEF_FEDCBA9876543210;
    load_mask(2'd0, M_ID);
    send(d, 2'b00, 2'd0, d);
    drain(n, b);
    checks++;
    if (n !== 4) begin
      failures++;
      $display("FAIL anf_id_latency got %0d need 4", n);
    end
    checks++;
    if (b !== 4) begin
      failures++;
      $display("FAIL anf_id_busy got %0d need 4", b);
    end
    e = pop();
    checks++;
    if (out_data !== e) begin
      failures++;
      $display("FAIL anf_id_data got %h need %h", out_data, e);
    end
    ack();
    checks++;
    if ({in_ready, out_valid} !== 2'b10) begin
      failures++;
      $display("FAIL anf_id_ack got %b need 10", {in_ready, out_valid});
    end
  endtask

  task automatic test_anf_invert;
    logic [127:0] d, e;
    logic [63:0] m;
    int n, b;
    load_mask(2'd1, M_INV);
    send('0, 2'b00, 2'd1, {128{1'b1}});
    drain(n, b);
    e = pop();
    checks++;
    if (out_data !== e) begin
      failures++;
      $display("FAIL anf_inv_zero got %h need %h", out_data, e);
    end
    ack();
    send({128{1'b1}}, 2'b00, 2'd1, '0);
    drain(n, b);
    e = pop();
    checks++;
    if (out_data !== e) begin
      failures++;
      $display("FAIL anf_inv_ones got %h need %h", out_data, e);
    end
    ack();
    m = {$urandom, $urandom};
    d = {$urandom, $urandom, $urandom, $urandom};
    load_mask(2'd2, m);
    send(d, 2'b00, 2'd2, anf_model(m, d));
    drain(n, b);
    e = pop();
    checks++;
    if (out_data !== e) begin
      failures++;
      $display("FAIL anf_rand got %h need %h", out_data, e);
    end
    ack();
  endtask

  task automatic test_aes;
    logic [127:0] d, c, e;
    int n, b;
    d = {96'h0, 32'h00530163};
    c = {32'h63636363, 32'h63636363, 32'h63636363, 32'h63ED7CFB};
    send(d, 2'b01, 2'd0, c);
    drain(n, b);
    e = pop();
    checks++;
    if (out_data !== e) begin
      failures++;
      $display("FAIL aes_enc got %h need %h", out_data, e);
    end
    ack();
    send(c, 2'b10, 2'd0, d);
    drain(n, b);
    e = pop();
    checks++;
    if (out_data !== e) begin
      failures++;
      $display("FAIL aes_dec got %h need %h", out_data, e);
    end
    ack();
    d = {$urandom, $urandom, $urandom, $urandom};
    send(d, 2'b01, 2'd3, aes_model(d, 1'b0));
    drain(n, b);
    e = pop();
    checks++;
    if (out_data !== e) begin
      failures++;
      $display("FAIL aes_enc_rand got %h need %h", out_data, e);
    end
    ack();
    send(d, 2'b10, 2'd3, aes_model(d, 1'b1));
    drain(n, b);
    e = pop();
    checks++;
    if (out_data !== e) begin
      failures++;
      $display("FAIL aes_dec_rand got %h need %h", out_data, e);
    end
    ack();
  endtask

  task automatic test_back_to_back;
    logic [127:0] da, db, hold, e;
    logic stable, bad;
    int n, b;
    da = {$urandom, $urandom, $urandom, $urandom};
    db = ~da;
    send(da, 2'b11, 2'd0, da);
    drain(n, b);
    hold = out_data;
    stable = 1'b1;
    bad = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
      if (out_data !== hold) stable = 1'b0;
      if (in_ready !== 1'b0 || out_valid !== 1'b1) bad = 1'b1;
    end
    checks++;
    if (!stable || bad) begin
      failures++;
      $display("FAIL hold_stall got stable=%b bad=%b need 1 0",
               stable, bad);
    end
    e = pop();
    checks++;
    if (out_data !== e) begin
      failures++;
      $display("FAIL hold_data got %h need %h", out_data, e);
    end
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_data = db;
    in_mode = 2'b11;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL b2b_ready got %b need 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    sb.push_back(db);
    checks++;
    if ({busy, out_valid} !== 2'b10) begin
      failures++;
      $display("FAIL b2b_accept got %b need 10", {busy, out_valid});
    end
    drain(n, b);
    checks++;
    if (n !== 4) begin
      failures++;
      $display("FAIL b2b_latency got %0d need 4", n);
    end
    e = pop();
    checks++;
    if (out_data !== e) begin
      failures++;
      $display("FAIL b2b_data got %h need %h", out_data, e);
    end
    ack();
  endtask

  task automatic test_mask_snapshot;
    logic [127:0] d, e;
    int n, b;
    d = 128'hDEADBEEF_01234567_89ABCDEF_C0FFEE11;
    in_valid = 1'b1;
    in_data = d;
    in_mode = 2'b00;
    in_msel = 2'd0;
    mask_we = 1'b1;
    mask_waddr = 2'd0;
    mask_wdata = '0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    sb.push_back(d);
    @(posedge clk); #1;
    mask_we = 1'b0;
    drain(n, b);
    e = pop();
    checks++;
    if (out_data !== e) begin
      failures++;
      $display("FAIL snap_old got %h need %h", out_data, e);
    end
    ack();
    send(d, 2'b00, 2'd0, '0);
    drain(n, b);
    e = pop();
    checks++;
    if (out_data !== e) begin
      failures++;
      $display("FAIL snap_new got %h need %h", out_data, e);
    end
    ack();
  endtask

  task automatic test_async_reset;
    logic [127:0] d, e;
    int n, b;
    d = 128'hA5A5A5A5_5A5A5A5A_12345678_9ABCDEF0;
    send(d, 2'b11, 2'd0, d);
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    void'(sb.pop_back());
    checks++;
    if ({in_ready, out_valid, busy} !== 3'b100) begin
      failures++;
      $display("FAIL arst_flags got %b need 100",
               {in_ready, out_valid, busy});
    end
    checks++;
    if (out_data !== '0) begin
      failures++;
      $display("FAIL arst_data got %h need 0", out_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL arst_ready got %b need 1", in_ready);
    end
    send('0, 2'b00, 2'd1, '0);
    drain(n, b);
    e = pop();
    checks++;
    if (out_data !== e) begin
      failures++;
      $display("FAIL arst_mask got %h need %h", out_data, e);
    end
    ack();
    send(~d, 2'b11, 2'd0, ~d);
    drain(n, b);
    e = pop();
    checks++;
    if (out_data !== e) begin
      failures++;
      $display("FAIL arst_bypass got %h need %h", out_data, e);
    end
    ack();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got timeout need finish");
    $fatal(1, "watchdog");
  end

  initial begin
    mask_we = 1'b0;
    mask_waddr = '0;
    mask_wdata = '0;
    in_valid = 1'b0;
    in_data = '0;
    in_mode = 2'b00;
    in_msel = '0;
    out_ready = 1'b0;
    build_sbox();
    test_reset();
    test_anf_identity();
    test_anf_invert();
    test_aes();
    test_back_to_back();
    test_mask_snapshot();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
